native_regfile: RTL and testbench

Register bank that consumes the native write/read interface produced by the AXI4-Lite-to-native bridge and provides control, status and interrupt registers to the rest of the design. It decodes single-cycle write and read pulses, answers every read with exactly one RVALID pulse, and aggregates event pulses into a maskable, write-one-to-clear interrupt. It sits directly downstream of the bridge, with its RDATA/RVALID wired back to it.

---
 rtl/native_regfile_pkg.sv | 49 ++++
 rtl/irq_w1c_reg.sv | 25 ++
 rtl/native_regfile.sv | 141 ++++++++++++++
 tb/tb_native_regfile.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/native_regfile_pkg.sv
// Shared register map and decode helpers for native_regfile.
package native_regfile_pkg;

  // Byte offsets of the register map; only bits [5:2] select a word.
  localparam logic [5:0] ID_OFF         = 6'h00;
  localparam logic [5:0] CTRL_OFF       = 6'h04;
  localparam logic [5:0] STATUS_OFF     = 6'h08;
  localparam logic [5:0] IRQ_STATUS_OFF = 6'h0C;
  localparam logic [5:0] IRQ_ENABLE_OFF = 6'h10;
  localparam logic [5:0] SCRATCH_OFF    = 6'h14;
  localparam logic [5:0] CYCLES_OFF     = 6'h18;
  localparam logic [5:0] GP_BASE_OFF    = 6'h20;

  typedef enum logic [3:0] {
    REG_NONE,
    REG_ID,
    REG_CTRL,
    REG_STATUS,
    REG_IRQ_STATUS,
    REG_IRQ_ENABLE,
    REG_SCRATCH,
    REG_CYCLES,
    REG_GP
  } reg_sel_e;

  // Map a word index (ADDR[5:2]) of an in-window access to a register select.
  // GP words start at index 8; only the first num_gp of them exist.
  function automatic reg_sel_e word_to_sel(input logic [3:0] widx,
                                           input logic [4:0] num_gp);
    reg_sel_e sel;
    sel = REG_NONE;
    case (widx)
      ID_OFF[5:2]:         sel = REG_ID;
      CTRL_OFF[5:2]:       sel = REG_CTRL;
      STATUS_OFF[5:2]:     sel = REG_STATUS;
      IRQ_STATUS_OFF[5:2]: sel = REG_IRQ_STATUS;
      IRQ_ENABLE_OFF[5:2]: sel = REG_IRQ_ENABLE;
      SCRATCH_OFF[5:2]:    sel = REG_SCRATCH;
      CYCLES_OFF[5:2]:     sel = REG_CYCLES;
      default: begin
        if ((widx >= GP_BASE_OFF[5:2]) &&
            (({1'b0, widx} - {1'b0, GP_BASE_OFF[5:2]}) < num_gp))
          sel = REG_GP;
      end
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/irq_w1c_reg.sv
// Sticky-set / write-one-to-clear register; a set wins over a clear of the same bit.
module irq_w1c_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] set,
  input  logic             clr_en,
  input  logic [WIDTH-1:0] clr_mask,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_next
);

  // Next value is exported so the owner can derive same-cycle aggregates.
  always_comb begin
    q_next = (q & ~(clr_en ? clr_mask : '0)) | set;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= q_next;
  end

endmodule

// File: rtl/native_regfile.sv
// Control/status/interrupt register bank behind the native write/read interface.
module native_regfile
  import native_regfile_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    NUM_GP     = 4,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hC0DE_0001
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WEN,
  input  logic [ADDR_WIDTH-1:0] WADDR,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  REN,
  input  logic [ADDR_WIDTH-1:0] RADDR,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  RVALID,
  output logic [DATA_WIDTH-1:0] CTRL,
  output logic                  CTRL_UPDATE,
  input  logic [DATA_WIDTH-1:0] STATUS_IN,
  input  logic [DATA_WIDTH-1:0] IRQ_EVENT,
  output logic                  IRQ
);

  logic [DATA_WIDTH-1:0] ctrl_q;
  logic [DATA_WIDTH-1:0] status_q;
  logic [DATA_WIDTH-1:0] irq_en_q;
  logic [DATA_WIDTH-1:0] irq_en_d;
  logic [DATA_WIDTH-1:0] irq_status_q;
  logic [DATA_WIDTH-1:0] irq_status_d;
  logic [DATA_WIDTH-1:0] scratch_q;
  logic [DATA_WIDTH-1:0] cycles_q;
  logic [DATA_WIDTH-1:0] gp_q [NUM_GP];
  logic [DATA_WIDTH-1:0] rd_mux;

  reg_sel_e   wsel;
  reg_sel_e   rsel;
  logic [3:0] widx;
  logic [3:0] ridx;
  logic       wr_ctrl;
  logic       wr_irq_status;
  logic       wr_irq_enable;
  logic       wr_scratch;
  logic       wr_cycles;
  logic       unused_addr_lsb;

  assign unused_addr_lsb = ^{WADDR[1:0], RADDR[1:0]};

  // Any address bit above the 64-byte window makes the access unmapped.
  function automatic reg_sel_e decode(input logic [ADDR_WIDTH-1:0] addr);
    if (|addr[ADDR_WIDTH-1:6]) return REG_NONE;
    return word_to_sel(addr[5:2], 5'(NUM_GP));
  endfunction

  // Shared address decode for the write and read ports.
  always_comb begin
    wsel          = decode(WADDR);
    rsel          = decode(RADDR);
    widx          = WADDR[5:2];
    ridx          = RADDR[5:2];
    wr_ctrl       = WEN && (wsel == REG_CTRL);
    wr_irq_status = WEN && (wsel == REG_IRQ_STATUS);
    wr_irq_enable = WEN && (wsel == REG_IRQ_ENABLE);
    wr_scratch    = WEN && (wsel == REG_SCRATCH);
    wr_cycles     = WEN && (wsel == REG_CYCLES);
    irq_en_d      = wr_irq_enable ? WDATA : irq_en_q;
  end

  irq_w1c_reg #(
    .WIDTH (DATA_WIDTH)
  ) u_irq_status (
    .clk      (CLK),
    .rst      (RST),
    .set      (IRQ_EVENT),
    .clr_en   (wr_irq_status),
    .clr_mask (WDATA),
    .q        (irq_status_q),
    .q_next   (irq_status_d)
  );

  // Writable registers, status capture, cycle counter and registered IRQ.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ctrl_q      <= '0;
      CTRL_UPDATE <= 1'b0;
      status_q    <= '0;
      irq_en_q    <= '0;
      scratch_q   <= '0;
      cycles_q    <= '0;
      IRQ         <= 1'b0;
      for (int i = 0; i < NUM_GP; i++) gp_q[i] <= '0;
    end else begin
      status_q    <= STATUS_IN;
      CTRL_UPDATE <= wr_ctrl;
      irq_en_q    <= irq_en_d;
      IRQ         <= |(irq_status_d & irq_en_d);
      cycles_q    <= wr_cycles ? '0 : cycles_q + 1'b1;
      if (wr_ctrl)    ctrl_q    <= WDATA;
      if (wr_scratch) scratch_q <= WDATA;
      // GP words sit at index 8 upward, so a 4-bit match on 8+i is unambiguous.
      for (int i = 0; i < NUM_GP; i++) begin
        if (WEN && (wsel == REG_GP) && (widx == 4'(8 + i))) gp_q[i] <= WDATA;
      end
    end
  end

  // Read data selection from current register state.
  always_comb begin
    rd_mux = '0;
    case (rsel)
      REG_ID:         rd_mux = ID_VALUE;
      REG_CTRL:       rd_mux = ctrl_q;
      REG_STATUS:     rd_mux = status_q;
      REG_IRQ_STATUS: rd_mux = irq_status_q;
      REG_IRQ_ENABLE: rd_mux = irq_en_q;
      REG_SCRATCH:    rd_mux = scratch_q;
      REG_CYCLES:     rd_mux = cycles_q;
      REG_GP: begin
        for (int i = 0; i < NUM_GP; i++) begin
          if (ridx == 4'(8 + i)) rd_mux = gp_q[i];
        end
      end
      default:        rd_mux = '0;
    endcase
  end

  // One-cycle read response; RDATA holds until the next response.
  always_ff @(posedge CLK) begin
    if (RST) begin
      RVALID <= 1'b0;
      RDATA  <= '0;
    end else begin
      RVALID <= REN;
      if (REN) RDATA <= rd_mux;
    end
  end

  assign CTRL = ctrl_q;

endmodule

// File: tb/tb_native_regfile.sv
// Scoreboard bench for native_regfile: directed map/IRQ cases, then random traffic.
module tb_native_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        ren;
  logic [31:0] raddr;
  logic [31:0] rdata;
  logic        rvalid;
  logic [31:0] ctrl;
  logic        ctrl_update;
  logic [31:0] status_in;
  logic [31:0] irq_event;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [$];

  // Reference model: architectural register contents.
  logic [31:0] m_ctrl, m_status, m_irqs, m_irqen, m_scratch, m_cycles;
  logic [31:0] m_gp [4];
  logic        m_cupd, m_irq, m_rv;

  always #5 clk = ~clk;

  native_regfile #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .NUM_GP     (4),
    .ID_VALUE   (32'hC0DE_0001)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .WEN         (wen),
    .WADDR       (waddr),
    .WDATA       (wdata),
    .REN         (ren),
    .RADDR       (raddr),
    .RDATA       (rdata),
    .RVALID      (rvalid),
    .CTRL        (ctrl),
    .CTRL_UPDATE (ctrl_update),
    .STATUS_IN   (status_in),
    .IRQ_EVENT   (irq_event),
    .IRQ         (irq)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int w;
    if (a[31:6] != 26'd0) return 32'd0;
    w = int'(a[5:2]);
    case (w)
      0: return 32'hC0DE_0001;
      1: return m_ctrl;
      2: return m_status;
      3: return m_irqs;
      4: return m_irqen;
      5: return m_scratch;
      6: return m_cycles;
      8, 9, 10, 11: return m_gp[w - 8];
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_update();
    int w;
    logic hit;
    logic [31:0] clr;
    if (rst) begin
      m_ctrl = 0; m_status = 0; m_irqs = 0; m_irqen = 0; m_scratch = 0; m_cycles = 0;
      for (int i = 0; i < 4; i++) m_gp[i] = 0;
      m_cupd = 0; m_irq = 0; m_rv = 0;
      return;
    end
    w   = int'(waddr[5:2]);
    hit = wen && (waddr[31:6] == 26'd0);
    clr = (hit && w == 3) ? wdata : 32'd0;
    m_irqs = (m_irqs & ~clr) | irq_event;
    if (hit && w == 1) m_ctrl = wdata;
    if (hit && w == 4) m_irqen = wdata;
    if (hit && w == 5) m_scratch = wdata;
    if (hit && w >= 8 && w < 12) m_gp[w - 8] = wdata;
    m_cycles = (hit && w == 6) ? 32'd0 : m_cycles + 32'd1;
    m_status = status_in;
    m_cupd   = hit && (w == 1);
    m_irq    = |(m_irqs & m_irqen);
    m_rv     = ren;
  endfunction

  // One clock: queue the expected read, advance model, check level outputs.
  task automatic step();
    status_in = $urandom;
    if (!rst && ren) exp_q.push_back(model_read(raddr));
    @(posedge clk);
    model_update();
    #1;
    chk("ctrl", ctrl, m_ctrl);
    chk("ctrl_update", {31'd0, ctrl_update}, {31'd0, m_cupd});
    chk("irq", {31'd0, irq}, {31'd0, m_irq});
    chk("rvalid", {31'd0, rvalid}, {31'd0, m_rv});
  endtask

  task automatic op(input logic w_en, input logic [31:0] wa, input logic [31:0] wd,
                    input logic r_en, input logic [31:0] ra, input logic [31:0] ev);
    wen = w_en; waddr = wa; wdata = wd; ren = r_en; raddr = ra; irq_event = ev;
    step();
    wen = 0; ren = 0; irq_event = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    op(1'b1, a, d, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic rd(input logic [31:0] a);
    op(1'b0, 32'd0, 32'd0, 1'b1, a, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
    if ($urandom_range(0, 9) == 0) a = a | (32'd1 << $urandom_range(6, 31));
    return a;
  endfunction

  // Monitor: every read response is matched against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rvalid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rdata_unexpected: got response %h with no read outstanding at %0t", rdata, $time);
        end else begin
          chk("rdata", rdata, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; wen = 0; waddr = 0; wdata = 0; ren = 0; raddr = 0; irq_event = 0; status_in = 0;
    step();
    step();
    chk("rdata_reset", rdata, 32'd0);
    rst = 0;

    rd(32'h00);
    rd(32'h04);
    rd(32'h18);

    wr(32'h04, 32'hA5A5_A5A5);
    op(0, 0, 0, 0, 0, 0);
    rd(32'h04);

    wr(32'h00, 32'h1234_5678);
    wr(32'h08, 32'h1234_5678);
    wr(32'h40, 32'h1234_5678);
    wr(32'h1000, 32'h1234_5678);
    rd(32'h00);
    rd(32'h08);
    rd(32'h40);
    rd(32'h1000);

    wr(32'h10, 32'h1);
    op(0, 0, 0, 0, 0, 32'h3);
    rd(32'h0C);
    wr(32'h0C, 32'h1);
    rd(32'h0C);

    op(1, 32'h0C, 32'h1, 0, 0, 32'h1);
    rd(32'h0C);
    wr(32'h10, 32'h0);
    wr(32'h10, 32'h2);

    wr(32'h14, 32'd1);
    wr(32'h20, 32'd2);
    wr(32'h2C, 32'd3);
    rd(32'h14);
    rd(32'h20);
    rd(32'h2C);

    op(1, 32'h14, 32'hDEAD_BEEF, 1, 32'h14, 32'd0);
    rd(32'h14);

    rst = 1;
    op(0, 0, 0, 1, 32'h00, 0);
    rst = 0;
    op(0, 0, 0, 0, 0, 0);
    rd(32'h04);

    for (int n = 0; n < 400; n++) begin
      logic        we, re;
      logic [31:0] ev;
      we = ($urandom_range(0, 2) == 0);
      re = ($urandom_range(0, 1) == 0);
      ev = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h0000_00FF) : 32'd0;
      op(we, rand_addr(), $urandom, re, rand_addr(), ev);
    end

    op(0, 0, 0, 0, 0, 0);
    op(0, 0, 0, 0, 0, 0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
